// File: rtl/sd_stream_mux_rr.sv
// Round-robin packet stream mux with a registered output beat.
// A grant is held from the first beat through in_last of that channel.
module sd_stream_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] cur_nx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nx;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] nxt_ptr;
  logic             any_req;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] chan [CHANNELS];
  logic [2*CHANNELS-1:0] rot;
  int               pos;
  int               wsum;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Rotate requests so bit 0 is ptr; the lowest set bit wins.
  always_comb begin
    rot     = {in_valid, in_valid} >> ptr;
    any_req = |in_valid;
    pos     = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    wsum = int'(ptr) + pos;
    if (wsum >= CHANNELS) wsum = wsum - CHANNELS;
    win = SEL_W'(wsum);
  end

  assign load_ok = !out_valid || out_ready;
  assign xfer    = (state == LOCKED)
                && in_valid[cur] && load_ok;
  assign nxt_ptr = (cur == SEL_W'(CHANNELS - 1))
                 ? '0 : cur + 1'b1;
  assign busy    = (state == LOCKED);

  always_comb begin
    in_ready = '0;
    if (state == LOCKED) in_ready[cur] = load_ok;
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = LOCKED;
          cur_nx   = win;
        end
      end
      LOCKED: begin
        if (xfer && in_last[cur]) begin
          state_nx = IDLE;
          ptr_nx   = nxt_ptr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      ptr   <= ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= in_last[cur];
      out_data  <= chan[cur];
      out_sel   <= cur;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sd_stream_mux_rr.md
# sd_stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with round-robin arbitration and valid/ready handshaking on every channel. It selects one requesting source, holds that selection for a whole packet (through the beat marked `in_last`), and presents the beats through a single output register. It sits between the command/data producers and the shared SD bus driver, and it replaces the fixed-select combinational muxes wherever the select must be arbitrated rather than decoded.

## Interface
- `WIDTH`, 16: data width per channel.
- `CHANNELS`, 4: number of input channels. Legal range is ≥1; the value need not be a power of 2.
- `SEL_W`: derived localparam, max(1, clog2(CHANNELS)).

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_data` input CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input CHANNELS: per-channel beat valid.
- `in_last` input CHANNELS: per-channel end-of-packet flag, qualified by `in_valid`.
- `in_ready` output CHANNELS: per-channel accept. At most one bit is high in any cycle.
- `out_data` output WIDTH: registered output beat.
- `out_valid` output 1: output beat valid.
- `out_last` output 1: output beat is the last beat of its packet.
- `out_sel` output SEL_W: source channel of the beat currently in the output register.
- `out_ready` input 1: downstream accept.
- `busy` output 1: high while a channel is locked (state LOCKED).

## Operation
- State machine with two states, IDLE and LOCKED, plus a `cur` register (granted channel) and a `ptr` register (round-robin start point).
- **IDLE:**
  - `in_ready` = 0.
  - If any `in_valid` is high, the winner is the first channel with `in_valid` high, searching `ptr`, `ptr`+1, … and wrapping modulo CHANNELS.
  - Next edge: `cur` ← winner, state ← LOCKED.
  - If no `in_valid` is high, the block stays in IDLE.
- **LOCKED:**
  - `in_ready[cur]` = `load_ok`, where `load_ok` = !`out_valid` | `out_ready`. All other `in_ready` bits are 0.
  - A transfer occurs when `in_valid[cur]` & `in_ready[cur]`. On a transfer, the output register loads `in_data[cur]`, `in_last[cur]` and `cur` (into `out_sel`), and `out_valid` ← 1.
  - A transfer with `in_last[cur]` = 1 sets state ← IDLE and `ptr` ← (`cur`+1 == CHANNELS) ? 0 : `cur`+1.
  - If `in_valid[cur]` drops mid-packet, the block stays LOCKED and does not transfer. Other channels are never granted until `last`.
- **Output register:**
  - If `out_valid` & `out_ready` with no new load, `out_valid` ← 0.
  - While `out_valid` & !`out_ready`, `out_data`, `out_last` and `out_sel` hold stable.
- Channel-to-channel isolation: beats from different channels never interleave within a packet.
- CHANNELS=1: the block degenerates to a registered pipe with a 1-cycle arbitration bubble per packet. `out_sel` = 0.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low):
  - State IDLE.
  - `cur` = 0, `ptr` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `out_sel` = 0.
  - `busy` = 0, `in_ready` = 0.
- Reset mid-packet discards the packet and any beat held in the output register. No output is produced until re-arbitration after reset.
- Latency:
  - `in_valid` first seen high in IDLE at cycle t → `in_ready` high at t+1 (output empty) → `out_valid` high at t+2.
  - Within a packet, throughput is 1 beat/cycle while `out_ready` = 1.
  - Between packets there is exactly one IDLE cycle (the arbitration bubble).
- Back-to-back: the output register may hold the last beat of packet A while arbitration for packet B runs. `in_ready` for B obeys `load_ok` like any beat.
- Simultaneous requests: `ptr` fixes priority. For CHANNELS=4 with all channels requesting continuously, the grant order is 0,1,2,3,0,…
- Wrap-around: `ptr` wraps to 0 after channel CHANNELS-1, including for non-power-of-2 CHANNELS (e.g. 3: 2→0).
- `in_valid` asserted then withdrawn during IDLE before the edge: no grant is made, because arbitration is sampled only at the edge.

## Test plan
- **Reset:** after reset, all 4 channels hold single-beat packets 0xA000+i with `last`=1, and `out_ready`=1 → `out_sel` sequence 0,1,2,3, `out_data` 0xA000..0xA003, one bubble cycle between packets, `busy` high during each grant.
- **Packet lock:** ch2 sends a 3-beat packet (0x2001, 0x2002, 0x2003 with `last`) while ch0 and ch1 are requesting → three consecutive ch2 beats, then ch3/ch0 per `ptr`=3, not ch1 first.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with a beat in the output register → `out_data`/`out_sel` stable, `in_ready[cur]`=0. Release → one beat per cycle with no loss or duplication, checked against a scoreboard.
- **Mid-packet gap:** ch1 drops `in_valid` for 3 cycles mid-packet while ch0 requests → no ch0 beat appears, ch1 resumes, `busy` stays high throughout.
- **Reset mid-packet and wrap:** assert `rst_n` low for 1 cycle mid-packet → outputs return to reset values immediately and `ptr`=0. Then with CHANNELS=3 and random traffic for 10k cycles → per-channel order preserved, no interleaving within packets, fair grant counts within ±1 packet.
